axi4_slave_mem: RTL and testbench
=================================

# axi4_slave_mem

AXI4 slave (responder) memory model terminating the full five-channel AXI4 bus used throughout the design. It accepts write and read bursts from any AXI4 master and services them from an internal word-addressed RAM. Write and read paths are independent state machines, so one write burst and one read burst can be in flight at the same time. It serves as the default target behind the bus in the top-level bench and as a synthesizable scratch RAM.

## Interface
- ID_WIDTH, 4, width of AWID/BID/ARID/RID
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width (32/64/128); BYTES = DATA_WIDTH/8, LB = log2(BYTES)
- MEM_DEPTH, 1024, RAM depth in DATA_WIDTH words; valid byte range 0 .. MEM_DEPTH*BYTES-1

Ports:
- clock  in  1  single clock; all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
- AWLOCK/AWCACHE/AWPROT/AWQOS  in  1/4/3/4  accepted, ignored
- AWVALID in 1; AWREADY out 1  AW handshake
- WDATA/WSTRB/WLAST/WVALID  in  DATA_WIDTH/BYTES/1/1  write data
- WREADY  out  1
- BID/BRESP/BVALID  out  ID_WIDTH/2/1  write response; BREADY in 1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  as AW
- ARLOCK/ARCACHE/ARPROT/ARQOS  in  ignored
- ARVALID in 1; ARREADY out 1
- RID/RDATA/RRESP/RLAST/RVALID  out  ID_WIDTH/DATA_WIDTH/2/1/1; RREADY in 1

## Operation
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. On AWVALID, latch ID, ADDR, LEN, SIZE, BURST; clear beat count and error flag; go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&&WREADY writes the byte lanes enabled by WSTRB at the current word, then advances the address. The burst ends on the beat where count==LEN. If WLAST disagrees with count==LEN on any beat, set the error flag; WLAST never ends the burst early.
  - W_RESP: BVALID=1, BID=latched ID, BRESP = 2'b10 (SLVERR) if the error flag is set, else 2'b00 (OKAY). Hold until BREADY, then go to W_IDLE.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1. On ARVALID, latch the AR fields and preload RDATA from the first address.
  - R_DATA: RVALID=1, RID=latched ID, RLAST = (count==LEN). On RREADY, advance the address and count and load the next RDATA. RRESP is per beat: SLVERR for an out-of-range beat (RDATA=0), else OKAY. After the last handshake go to R_IDLE.
- Address generation, with step = 1<<SIZE:
  - FIXED (00): address constant.
  - INCR (01): address += step.
  - WRAP (10): container = (LEN+1)*step, aligned down; address wraps to the container base on crossing its top.
  - Word index = addr >> LB.
- Error conditions (SLVERR):
  - BURST = 11
  - SIZE > LB
  - WRAP with LEN not in {1,3,7,15}
  - word index >= MEM_DEPTH
- On any error, the affected write beats are suppressed, but the handshakes still complete.
- The RAM is not reset; its contents survive reset.

## Timing
- Reset: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BID, BRESP, RID, RDATA, RRESP = 0; both FSMs go to IDLE.
- AWREADY and ARREADY assert on the first clock edge after ARESETn deasserts.
- All outputs are registered; no combinational path from any input to any output.
- AW handshake to WREADY=1: 1 cycle. Last W beat to BVALID: 1 cycle. AR handshake to first RVALID: 1 cycle, with data valid. Back-to-back R beats at 1 per cycle while RREADY=1.
- AWREADY=0 outside W_IDLE; ARREADY=0 outside R_IDLE. Next address acceptance occurs one cycle after the B or final R handshake.
- BVALID, RVALID and all payload signals are held stable while READY=0.
- A same-cycle write and read to the same word: the read returns the old data.
- Reset mid-burst aborts the burst; no B or R response is issued for it.

## Test plan
- Single beat: write 0xDEADBEEF to 0x40 (LEN=0, SIZE=2, INCR, ID=3), then read 0x40 -> BRESP=OKAY, BID=3; RDATA=0xDEADBEEF, RLAST=1, RID=3.
- INCR 4-beat at 0x100 with WSTRB=4'b0011 on beat 2; read back -> beat 2 upper 16 bits keep their old value; RLAST only on beat 4.
- WRAP LEN=3, SIZE=2 at 0x18 -> beats hit 0x18, 0x1C, 0x10, 0x14; FIXED 4-beat read -> same word returned 4 times.
- Backpressure: BREADY=0 for 5 cycles, RREADY toggling every cycle -> BVALID/BID and RVALID/RDATA held stable; no beat lost or duplicated; AWREADY stays 0 until the B handshake.
- Errors: write to MEM_DEPTH*BYTES, BURST=11, WRAP LEN=2 -> SLVERR and RAM unchanged; read beyond range -> RRESP=SLVERR, RDATA=0.
- Assert ARESETn=0 mid 8-beat read at beat 3 -> RVALID=0 immediately; no further beats; ARREADY=1 on the first edge after release; RAM contents intact.

Source files
------------

// File: rtl/axi4_slave_mem_if.sv
// AXI4 five-channel bus bundle between one master and the axi4_slave_mem responder.
// The master modport is for whatever drives requests; the slave modport is the memory side.
interface axi4_slave_mem_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BYTES = DATA_WIDTH / 8;

    // Write address channel
    logic [ID_WIDTH-1:0]   AWID;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWLOCK;
    logic [3:0]            AWCACHE;
    logic [2:0]            AWPROT;
    logic [3:0]            AWQOS;
    logic                  AWVALID;
    logic                  AWREADY;

    // Write data channel
    logic [DATA_WIDTH-1:0] WDATA;
    logic [BYTES-1:0]      WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    // Write response channel
    logic [ID_WIDTH-1:0]   BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    // Read address channel
    logic [ID_WIDTH-1:0]   ARID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARLOCK;
    logic [3:0]            ARCACHE;
    logic [2:0]            ARPROT;
    logic [3:0]            ARQOS;
    logic                  ARVALID;
    logic                  ARREADY;

    // Read data channel
    logic [ID_WIDTH-1:0]   RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 responder backed by a word-addressed RAM. Independent write and read
// state machines allow one write burst and one read burst in flight at once.
// Every bus output comes straight from a flop; the RAM itself is never reset.
module axi4_slave_mem #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic            clock,
    input  logic            ARESETn,
    axi4_slave_mem_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    // Burst-level illegal request: reserved burst type, beat wider than the bus,
    // or a wrapping burst whose length is not 2/4/8/16 beats.
    function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic err;
        if (burst == 2'b11) begin
            err = 1'b1;
        end else if (size > 3'(LB)) begin
            err = 1'b1;
        end else if ((burst == BURST_WRAP) &&
                     !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15))) begin
            err = 1'b1;
        end else begin
            err = 1'b0;
        end
        return err;
    endfunction

    // True when the byte address maps onto an implemented RAM word.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ((a >> LB) < ADDR_WIDTH'(MEM_DEPTH));
    endfunction

    // RAM word index of a byte address.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[LB +: IDX_W];
    endfunction

    // Address of the following beat for FIXED, INCR and WRAP bursts.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] cont;
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] res;
        step = ADDR_WIDTH'(1) << size;
        cont = ADDR_WIDTH'({1'b0, len} + 9'd1) << size;
        base = a & ~(cont - ADDR_WIDTH'(1));
        inc  = a + step;
        case (burst)
            BURST_FIXED: res = a;
            BURST_INCR:  res = inc;
            BURST_WRAP:  res = (inc >= (base + cont)) ? base : inc;
            default:     res = a;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------ storage
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // ------------------------------------------------------------- write path
    w_state_t              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   awid_q, awid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            awlen_q, awlen_d;
    logic [2:0]            awsize_q, awsize_d;
    logic [1:0]            awburst_q, awburst_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic                  werr_q, werr_d;
    logic                  wbad_q, wbad_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  mem_we_s;
    logic                  wlast_beat_s;

    // ------------------------------------------------------------- read path
    r_state_t              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   arid_q, arid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [1:0]            arburst_q, arburst_d;
    logic [7:0]            rcnt_q, rcnt_d;
    logic                  rbad_q, rbad_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic [DATA_WIDTH-1:0] mem_rd_s;
    logic                  rd_err_s;

    // Sideband qualifiers carry no meaning for a plain RAM.
    logic unused_s;
    assign unused_s = ^{bus.AWLOCK, bus.AWCACHE, bus.AWPROT, bus.AWQOS,
                        bus.ARLOCK, bus.ARCACHE, bus.ARPROT, bus.ARQOS};

    // Write FSM next state: accept AW, absorb beats until count==LEN, then respond.
    always_comb begin
        w_state_d    = w_state_q;
        awid_d       = awid_q;
        waddr_d      = waddr_q;
        awlen_d      = awlen_q;
        awsize_d     = awsize_q;
        awburst_d    = awburst_q;
        wcnt_d       = wcnt_q;
        werr_d       = werr_q;
        wbad_d       = wbad_q;
        bvalid_d     = bvalid_q;
        bid_d        = bid_q;
        bresp_d      = bresp_q;
        mem_we_s     = 1'b0;
        wlast_beat_s = (wcnt_q == awlen_q);
        case (w_state_q)
            W_IDLE: begin
                if (bus.AWVALID && awready_q) begin
                    awid_d    = bus.AWID;
                    waddr_d   = bus.AWADDR;
                    awlen_d   = bus.AWLEN;
                    awsize_d  = bus.AWSIZE;
                    awburst_d = bus.AWBURST;
                    wcnt_d    = 8'd0;
                    wbad_d    = burst_err(bus.AWLEN, bus.AWSIZE, bus.AWBURST);
                    werr_d    = burst_err(bus.AWLEN, bus.AWSIZE, bus.AWBURST);
                    w_state_d = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (bus.WVALID && wready_q) begin
                    // Illegal bursts and out-of-range beats still handshake but never touch RAM.
                    if (!wbad_q && in_range(waddr_q)) begin
                        mem_we_s = 1'b1;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                    werr_d  = werr_q | !in_range(waddr_q) | (bus.WLAST != wlast_beat_s);
                    waddr_d = next_addr(waddr_q, awlen_q, awsize_q, awburst_q);
                    wcnt_d  = wcnt_q + 8'd1;
                    // The beat count alone ends the burst; WLAST only feeds the error flag.
                    if (wlast_beat_s) begin
                        w_state_d = W_RESP;
                        bvalid_d  = 1'b1;
                        bid_d     = awid_q;
                        bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_state_d = W_DATA;
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (bus.BREADY && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                bvalid_d  = 1'b0;
            end
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
    end

    // Write FSM state and write-channel output registers.
    always_ff @(posedge clock or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            awid_q    <= '0;
            waddr_q   <= '0;
            awlen_q   <= 8'd0;
            awsize_q  <= 3'd0;
            awburst_q <= 2'd0;
            wcnt_q    <= 8'd0;
            werr_q    <= 1'b0;
            wbad_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            awid_q    <= awid_d;
            waddr_q   <= waddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            wbad_q    <= wbad_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    // RAM byte-lane write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.WSTRB[i]) begin
                    mem_q[word_idx(waddr_q)][i*8 +: 8] <= bus.WDATA[i*8 +: 8];
                end
            end
        end
    end

    // The single read port looks at the AR address while idle and at the
    // following beat address mid-burst, so RDATA is loaded one beat ahead.
    assign rd_addr_s = (r_state_q == R_IDLE) ? bus.ARADDR
                                              : next_addr(raddr_q, arlen_q, arsize_q, arburst_q);
    assign mem_rd_s  = mem_q[word_idx(rd_addr_s)];

    // Read FSM next state: accept AR with first data preloaded, then stream beats.
    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        raddr_d   = raddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        rcnt_d    = rcnt_q;
        rbad_d    = rbad_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_err_s  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (bus.ARVALID && arready_q) begin
                    rd_err_s  = burst_err(bus.ARLEN, bus.ARSIZE, bus.ARBURST) | !in_range(bus.ARADDR);
                    arid_d    = bus.ARID;
                    raddr_d   = bus.ARADDR;
                    arlen_d   = bus.ARLEN;
                    arsize_d  = bus.ARSIZE;
                    arburst_d = bus.ARBURST;
                    rcnt_d    = 8'd0;
                    rbad_d    = burst_err(bus.ARLEN, bus.ARSIZE, bus.ARBURST);
                    rvalid_d  = 1'b1;
                    rid_d     = bus.ARID;
                    rlast_d   = (bus.ARLEN == 8'd0);
                    rresp_d   = rd_err_s ? RESP_SLVERR : RESP_OKAY;
                    rdata_d   = rd_err_s ? '0 : mem_rd_s;
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (bus.RREADY && rvalid_q) begin
                    if (rcnt_q == arlen_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        rd_err_s  = rbad_q | !in_range(rd_addr_s);
                        raddr_d   = rd_addr_s;
                        rcnt_d    = rcnt_q + 8'd1;
                        rlast_d   = ((rcnt_q + 8'd1) == arlen_q);
                        rresp_d   = rd_err_s ? RESP_SLVERR : RESP_OKAY;
                        rdata_d   = rd_err_s ? '0 : mem_rd_s;
                        r_state_d = R_DATA;
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // Read FSM state and read-channel output registers.
    always_ff @(posedge clock or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            arid_q    <= '0;
            raddr_q   <= '0;
            arlen_q   <= 8'd0;
            arsize_q  <= 3'd0;
            arburst_q <= 2'd0;
            rcnt_q    <= 8'd0;
            rbad_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            arid_q    <= arid_d;
            raddr_q   <= raddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            rcnt_q    <= rcnt_d;
            rbad_q    <= rbad_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BID     = bid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RLAST   = rlast_q;
    assign bus.RID     = rid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed self-checking bench for axi4_slave_mem: inputs change 1 time unit
// after a rising edge, outputs are sampled on the falling edge.
module tb_axi4_slave_mem;
    localparam int IDW   = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] wdata_v [16];
    logic [3:0]  wstrb_v [16];
    logic [31:0] rdata_v [16];
    logic [1:0]  rresp_v [16];
    logic        rlast_v [16];
    logic [3:0]  rid_v   [16];

    always #5 clk = ~clk;

    axi4_slave_mem_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_slave_mem #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .clock  (clk),
        .ARESETn(rst_n),
        .bus    (bus)
    );

    task automatic init_inputs();
        bus.AWID = 4'd0; bus.AWADDR = 32'd0; bus.AWLEN = 8'd0; bus.AWSIZE = 3'd0; bus.AWBURST = 2'd0;
        bus.AWLOCK = 1'b0; bus.AWCACHE = 4'd0; bus.AWPROT = 3'd0; bus.AWQOS = 4'd0; bus.AWVALID = 1'b0;
        bus.WDATA = 32'd0; bus.WSTRB = 4'd0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARID = 4'd0; bus.ARADDR = 32'd0; bus.ARLEN = 8'd0; bus.ARSIZE = 3'd0; bus.ARBURST = 2'd0;
        bus.ARLOCK = 1'b0; bus.ARCACHE = 4'd0; bus.ARPROT = 3'd0; bus.ARQOS = 4'd0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit tmo);
        logic hs;
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
        bus.AWVALID = 1'b1;
        tmo = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); hs = bus.AWREADY;
            @(posedge clk); #1;
            if (hs) begin tmo = 1'b0; break; end
        end
        bus.AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                          output bit tmo);
        logic hs;
        bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
        tmo = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); hs = bus.WREADY;
            @(posedge clk); #1;
            if (hs) begin tmo = 1'b0; break; end
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    endtask

    task automatic get_b(output logic [3:0] bid, output logic [1:0] bresp, output bit tmo);
        bus.BREADY = 1'b1;
        tmo = 1'b1; bid = 4'd0; bresp = 2'd0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.BVALID) begin bid = bus.BID; bresp = bus.BRESP; tmo = 1'b0; end
            @(posedge clk); #1;
            if (!tmo) break;
        end
        bus.BREADY = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            output logic [3:0] bid, output logic [1:0] bresp, output bit tmo);
        bit t;
        send_aw(id, addr, len, size, burst, t);
        tmo = t;
        for (int i = 0; i <= int'(len); i++) begin
            send_w(wdata_v[i], wstrb_v[i], (i == int'(len)), t);
            tmo = tmo | t;
        end
        get_b(bid, bresp, t);
        tmo = tmo | t;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit tmo);
        logic hs;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst;
        bus.ARVALID = 1'b1;
        tmo = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); hs = bus.ARREADY;
            @(posedge clk); #1;
            if (hs) begin tmo = 1'b0; break; end
        end
        bus.ARVALID = 1'b0;
    endtask

    task automatic collect_r(input logic [7:0] len, output bit tmo);
        int n;
        n = 0;
        bus.RREADY = 1'b1;
        for (int c = 0; c < 60 && n <= int'(len); c++) begin
            @(negedge clk);
            if (bus.RVALID) begin
                rdata_v[n] = bus.RDATA; rresp_v[n] = bus.RRESP;
                rlast_v[n] = bus.RLAST; rid_v[n] = bus.RID;
                n++;
            end
            @(posedge clk); #1;
        end
        bus.RREADY = 1'b0;
        tmo = (n != int'(len) + 1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit tmo);
        bit t1;
        bit t2;
        send_ar(id, addr, len, size, burst, t1);
        collect_r(len, t2);
        tmo = t1 | t2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        init_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID, bus.RLAST} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID, bus.RLAST});
        end
        checks++;
        if ({bus.BID, bus.BRESP, bus.RID, bus.RRESP, bus.RDATA} !== 44'h0) begin
            errors++;
            $display("FAIL reset_payload: got %h expected 0",
                     {bus.BID, bus.BRESP, bus.RID, bus.RRESP, bus.RDATA});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.AWREADY, bus.ARREADY} !== 2'b00) begin
            errors++;
            $display("FAIL ready_before_edge: got %b expected 00", {bus.AWREADY, bus.ARREADY});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.AWREADY, bus.ARREADY} !== 2'b11) begin
            errors++;
            $display("FAIL ready_after_edge: got %b expected 11", {bus.AWREADY, bus.ARREADY});
        end
    endtask

    task automatic test_single();
        bit t;
        logic [3:0] bid;
        logic [1:0] bresp;
        send_aw(4'd3, 32'h40, 8'd0, 3'd2, 2'b01, t);
        checks++;
        if (t || bus.WREADY !== 1'b1) begin
            errors++;
            $display("FAIL single_wready: got tmo=%0d wready=%b expected wready=1", t, bus.WREADY);
        end
        send_w(32'hDEAD_BEEF, 4'hF, 1'b1, t);
        checks++;
        if (t || bus.BVALID !== 1'b1) begin
            errors++;
            $display("FAIL single_bvalid_latency: got tmo=%0d bvalid=%b expected 1", t, bus.BVALID);
        end
        get_b(bid, bresp, t);
        checks++;
        if (t || bid !== 4'd3 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL single_b: got tmo=%0d bid=%h bresp=%b expected bid=3 bresp=00", t, bid, bresp);
        end
        send_ar(4'd3, 32'h40, 8'd0, 3'd2, 2'b01, t);
        checks++;
        if (t || bus.RVALID !== 1'b1 || bus.RDATA !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_r_latency: got tmo=%0d rvalid=%b rdata=%h expected 1 deadbeef",
                     t, bus.RVALID, bus.RDATA);
        end
        collect_r(8'd0, t);
        checks++;
        if (t || rdata_v[0] !== 32'hDEAD_BEEF || rlast_v[0] !== 1'b1 || rid_v[0] !== 4'd3 || rresp_v[0] !== 2'b00) begin
            errors++;
            $display("FAIL single_r: got tmo=%0d data=%h last=%b id=%h resp=%b expected deadbeef 1 3 00",
                     t, rdata_v[0], rlast_v[0], rid_v[0], rresp_v[0]);
        end
        checks++;
        if (bus.RVALID !== 1'b0) begin
            errors++;
            $display("FAIL single_r_extra: got rvalid=%b expected 0", bus.RVALID);
        end
    endtask

    task automatic test_incr();
        bit t;
        logic [3:0] bid;
        logic [1:0] bresp;
        logic [31:0] exp_d [4];
        exp_d[0] = 32'hA0A0_B0B0; exp_d[1] = 32'h2222_B1B1;
        exp_d[2] = 32'hA2A2_B2B2; exp_d[3] = 32'hA3A3_B3B3;
        wdata_v[0] = 32'h1111_0000; wdata_v[1] = 32'h2222_0001;
        wdata_v[2] = 32'h3333_0002; wdata_v[3] = 32'h4444_0003;
        for (int i = 0; i < 4; i++) wstrb_v[i] = 4'hF;
        do_write(4'd1, 32'h100, 8'd3, 3'd2, 2'b01, bid, bresp, t);
        wdata_v[0] = 32'hA0A0_B0B0; wdata_v[1] = 32'hA1A1_B1B1;
        wdata_v[2] = 32'hA2A2_B2B2; wdata_v[3] = 32'hA3A3_B3B3;
        wstrb_v[1] = 4'b0011;
        do_write(4'd2, 32'h100, 8'd3, 3'd2, 2'b01, bid, bresp, t);
        checks++;
        if (t || bid !== 4'd2 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL incr_b: got tmo=%0d bid=%h bresp=%b expected 2 00", t, bid, bresp);
        end
        do_read(4'd4, 32'h100, 8'd3, 3'd2, 2'b01, t);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (t || rdata_v[i] !== exp_d[i] || rlast_v[i] !== (i == 3) || rresp_v[i] !== 2'b00) begin
                errors++;
                $display("FAIL incr_beat%0d: got tmo=%0d data=%h last=%b resp=%b expected data=%h last=%0d",
                         i, t, rdata_v[i], rlast_v[i], rresp_v[i], exp_d[i], (i == 3));
            end
        end
    endtask

    task automatic test_wrap_fixed();
        bit t;
        logic [3:0] bid;
        logic [1:0] bresp;
        logic [31:0] exp_d [4];
        wdata_v[0] = 32'hD000_0018; wdata_v[1] = 32'hD100_001C;
        wdata_v[2] = 32'hD200_0010; wdata_v[3] = 32'hD300_0014;
        for (int i = 0; i < 4; i++) wstrb_v[i] = 4'hF;
        do_write(4'd6, 32'h18, 8'd3, 3'd2, 2'b10, bid, bresp, t);
        checks++;
        if (t || bresp !== 2'b00) begin
            errors++;
            $display("FAIL wrap_b: got tmo=%0d bresp=%b expected 00", t, bresp);
        end
        exp_d[0] = 32'hD200_0010; exp_d[1] = 32'hD300_0014;
        exp_d[2] = 32'hD000_0018; exp_d[3] = 32'hD100_001C;
        do_read(4'd6, 32'h10, 8'd3, 3'd2, 2'b01, t);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (t || rdata_v[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL wrap_beat%0d: got tmo=%0d data=%h expected %h", i, t, rdata_v[i], exp_d[i]);
            end
        end
        do_read(4'd7, 32'h1C, 8'd3, 3'd2, 2'b00, t);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (t || rdata_v[i] !== 32'hD100_001C || rlast_v[i] !== (i == 3)) begin
                errors++;
                $display("FAIL fixed_beat%0d: got tmo=%0d data=%h last=%b expected d100001c last=%0d",
                         i, t, rdata_v[i], rlast_v[i], (i == 3));
            end
        end
    endtask

    task automatic test_backpressure();
        bit t;
        logic [3:0] bid;
        logic [1:0] bresp;
        int n;
        logic stalled;
        logic [31:0] prev_d;
        logic prev_l;
        send_aw(4'd5, 32'h200, 8'd0, 3'd2, 2'b01, t);
        send_w(32'h5A5A_0001, 4'hF, 1'b1, t);
        bus.BREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.BVALID !== 1'b1 || bus.BID !== 4'd5 || bus.BRESP !== 2'b00 || bus.AWREADY !== 1'b0) begin
                errors++;
                $display("FAIL b_hold%0d: got bvalid=%b bid=%h bresp=%b awready=%b expected 1 5 00 0",
                         k, bus.BVALID, bus.BID, bus.BRESP, bus.AWREADY);
            end
            @(posedge clk); #1;
        end
        get_b(bid, bresp, t);
        checks++;
        if (t || bid !== 4'd5 || bus.AWREADY !== 1'b1 || bus.BVALID !== 1'b0) begin
            errors++;
            $display("FAIL b_release: got tmo=%0d bid=%h awready=%b bvalid=%b expected 5 1 0",
                     t, bid, bus.AWREADY, bus.BVALID);
        end
        for (int i = 0; i < 4; i++) begin wdata_v[i] = 32'hC0C0_0000 + i; wstrb_v[i] = 4'hF; end
        do_write(4'd5, 32'h300, 8'd3, 3'd2, 2'b01, bid, bresp, t);
        send_ar(4'd9, 32'h300, 8'd3, 3'd2, 2'b01, t);
        bus.RREADY = 1'b0;
        n = 0; stalled = 1'b0; prev_d = 32'd0; prev_l = 1'b0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (bus.RVALID) begin
                if (stalled) begin
                    checks++;
                    if (bus.RDATA !== prev_d || bus.RLAST !== prev_l) begin
                        errors++;
                        $display("FAIL r_hold: got data=%h last=%b expected %h %b", bus.RDATA, bus.RLAST, prev_d, prev_l);
                    end
                end
                if (bus.RREADY) begin
                    rdata_v[n] = bus.RDATA; rlast_v[n] = bus.RLAST; n++;
                end
                stalled = !bus.RREADY; prev_d = bus.RDATA; prev_l = bus.RLAST;
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk); #1;
            bus.RREADY = ~bus.RREADY;
        end
        bus.RREADY = 1'b0;
        checks++;
        if (n != 4 || bus.RVALID !== 1'b0) begin
            errors++;
            $display("FAIL r_toggle_count: got beats=%0d rvalid=%b expected 4 0", n, bus.RVALID);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (rdata_v[i] !== 32'hC0C0_0000 + i || rlast_v[i] !== (i == 3)) begin
                errors++;
                $display("FAIL r_toggle_beat%0d: got %h last=%b expected %h last=%0d",
                         i, rdata_v[i], rlast_v[i], 32'hC0C0_0000 + i, (i == 3));
            end
        end
    endtask

    task automatic test_errors();
        bit t;
        logic [3:0] bid;
        logic [1:0] bresp;
        wdata_v[0] = 32'h0000_ABCD; wdata_v[1] = 32'h0000_1234; wdata_v[2] = 32'h0000_5678;
        for (int i = 0; i < 4; i++) wstrb_v[i] = 4'hF;
        do_write(4'd1, 32'h0, 8'd2, 3'd2, 2'b01, bid, bresp, t);
        wdata_v[0] = 32'hDDDD_DDDD;
        do_write(4'd2, 32'h1000, 8'd0, 3'd2, 2'b01, bid, bresp, t);
        checks++;
        if (t || bresp !== 2'b10 || bid !== 4'd2) begin
            errors++;
            $display("FAIL err_oor_write: got tmo=%0d bid=%h bresp=%b expected 2 10", t, bid, bresp);
        end
        wdata_v[0] = 32'hFFFF_FFFF;
        do_write(4'd3, 32'h0, 8'd0, 3'd2, 2'b11, bid, bresp, t);
        checks++;
        if (t || bresp !== 2'b10) begin
            errors++;
            $display("FAIL err_burst11: got tmo=%0d bresp=%b expected 10", t, bresp);
        end
        for (int i = 0; i < 3; i++) wdata_v[i] = 32'hEEEE_EEEE;
        do_write(4'd4, 32'h0, 8'd2, 3'd2, 2'b10, bid, bresp, t);
        checks++;
        if (t || bresp !== 2'b10) begin
            errors++;
            $display("FAIL err_wrap_len2: got tmo=%0d bresp=%b expected 10", t, bresp);
        end
        do_read(4'd1, 32'h0, 8'd2, 3'd2, 2'b01, t);
        checks++;
        if (t || rdata_v[0] !== 32'h0000_ABCD || rdata_v[1] !== 32'h0000_1234 || rdata_v[2] !== 32'h0000_5678) begin
            errors++;
            $display("FAIL err_ram_intact: got tmo=%0d %h %h %h expected 0000abcd 00001234 00005678",
                     t, rdata_v[0], rdata_v[1], rdata_v[2]);
        end
        send_aw(4'd8, 32'h20, 8'd1, 3'd2, 2'b01, t);
        send_w(32'h1, 4'hF, 1'b1, t);
        send_w(32'h2, 4'hF, 1'b0, t);
        get_b(bid, bresp, t);
        checks++;
        if (t || bresp !== 2'b10) begin
            errors++;
            $display("FAIL err_wlast: got tmo=%0d bresp=%b expected 10", t, bresp);
        end
        wdata_v[0] = 32'h7777_7777;
        do_write(4'd1, 32'hFFC, 8'd0, 3'd2, 2'b01, bid, bresp, t);
        do_read(4'd2, 32'hFFC, 8'd1, 3'd2, 2'b01, t);
        checks++;
        if (t || rdata_v[0] !== 32'h7777_7777 || rresp_v[0] !== 2'b00 || rdata_v[1] !== 32'h0 || rresp_v[1] !== 2'b10) begin
            errors++;
            $display("FAIL err_oor_read: got tmo=%0d %h/%b %h/%b expected 77777777/00 00000000/10",
                     t, rdata_v[0], rresp_v[0], rdata_v[1], rresp_v[1]);
        end
        do_read(4'd3, 32'h0, 8'd0, 3'd2, 2'b11, t);
        checks++;
        if (t || rdata_v[0] !== 32'h0 || rresp_v[0] !== 2'b10) begin
            errors++;
            $display("FAIL err_read_burst11: got tmo=%0d %h/%b expected 00000000/10", t, rdata_v[0], rresp_v[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit t;
        logic [3:0] bid;
        logic [1:0] bresp;
        int n;
        for (int i = 0; i < 8; i++) begin wdata_v[i] = 32'h8000_0000 + i; wstrb_v[i] = 4'hF; end
        do_write(4'd1, 32'h400, 8'd7, 3'd2, 2'b01, bid, bresp, t);
        send_ar(4'd2, 32'h400, 8'd7, 3'd2, 2'b01, t);
        bus.RREADY = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            if (bus.RVALID) begin rdata_v[n] = bus.RDATA; n++; end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (n != 3 || bus.RVALID !== 1'b0 || bus.RLAST !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_immediate: got beats=%0d rvalid=%b rlast=%b expected 3 0 0", n, bus.RVALID, bus.RLAST);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (rdata_v[i] !== 32'h8000_0000 + i) begin
                errors++;
                $display("FAIL rst_mid_beat%0d: got %h expected %h", i, rdata_v[i], 32'h8000_0000 + i);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_held: got rvalid=%b arready=%b expected 0 0", bus.RVALID, bus.ARREADY);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.RREADY = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ARREADY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_arready_early: got %b expected 0", bus.ARREADY);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.ARREADY !== 1'b1 || bus.RVALID !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: got arready=%b rvalid=%b expected 1 0", bus.ARREADY, bus.RVALID);
        end
        do_read(4'd3, 32'h400, 8'd7, 3'd2, 2'b01, t);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (t || rdata_v[i] !== 32'h8000_0000 + i) begin
                errors++;
                $display("FAIL rst_mid_intact%0d: got tmo=%0d %h expected %h", i, t, rdata_v[i], 32'h8000_0000 + i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr();
        test_wrap_fixed();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
